// File: rtl/sc_rr_crossbar_port_arbiter.sv
// -----------------------------------------------------------------------------
// sc_rr_crossbar_port_arbiter
//
// Round-robin arbiter for one slave port of a 4-master crossbar. While the
// port is IDLE, a pending request is granted one cycle after it is seen,
// searching from the master after the one granted most recently. The grant
// is held (BUSY) until the slave acks or the granted master withdraws its
// request. Every release returns to IDLE for at least one cycle before the
// next grant.
//
// Optional feature (macro SC_RR_XBAR_TIMEOUT_EN):
//   A BUSY watchdog. If the slave neither acks nor sees an abort within
//   TMO_CYCLES cycles of the grant, the grant is released and o_timeout
//   pulses for one cycle. Without the macro no counter is built and
//   o_timeout is tied low.
//
// Parameters:
//   TMO_CYCLES  BUSY cycles before a forced release (timeout build only)
//
// Ports:
//   i_clk       clock, rising edge
//   i_resetb    asynchronous active-low reset
//   i_ms_req    [3:0] per-master request level, held until ack
//   i_sl_ack    slave transaction-complete strobe, one cycle
//   o_ms_en     [3:0] registered one-hot grant (zero in IDLE)
//   o_sl_sel    [1:0] registered index of granted master, held in IDLE
//   o_busy      slave port owned
//   o_timeout   one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module sc_rr_crossbar_port_arbiter #(
  parameter logic [7:0] TMO_CYCLES = 8'd200
) (
  input  logic       i_clk,
  input  logic       i_resetb,
  input  logic [3:0] i_ms_req,
  input  logic       i_sl_ack,
  output logic [3:0] o_ms_en,
  output logic [1:0] o_sl_sel,
  output logic       o_busy,
  output logic       o_timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e     state_q,   state_d;
  logic [3:0] ms_en_q,   ms_en_d;
  logic [1:0] sel_q,     sel_d;
  logic [1:0] last_q,    last_d;
  logic       timeout_q, timeout_d;

`ifdef SC_RR_XBAR_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  // Rotating priority search: last+1, last+2, last+3, last (mod 4).
  logic       pick_found;
  logic [1:0] pick_idx;

  always_comb begin
    logic [1:0] scan_idx;
    pick_found = 1'b0;
    pick_idx   = last_q;
    scan_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!pick_found && i_ms_req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Ack and abort in the same cycle collapse into this single release.
  logic release_w;
  assign release_w = i_sl_ack || !i_ms_req[sel_q];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    state_d   = state_q;
    ms_en_d   = ms_en_q;
    sel_d     = sel_q;
    last_d    = last_q;
    timeout_d = 1'b0;
`ifdef SC_RR_XBAR_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // i_sl_ack is ignored here; only requests matter.
        if (pick_found) begin
          state_d = ST_BUSY;
          ms_en_d = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          last_d  = pick_idx;
`ifdef SC_RR_XBAR_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end

      ST_BUSY: begin
        if (release_w) begin
          state_d = ST_IDLE;
          ms_en_d = 4'b0000;
        end
`ifdef SC_RR_XBAR_TIMEOUT_EN
        // Ack/abort win over expiry. last_q keeps the timed-out master so
        // it becomes lowest priority for the next search.
        else if (cnt_q == TMO_CYCLES - 8'd1) begin
          state_d   = ST_IDLE;
          ms_en_d   = 4'b0000;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        ms_en_d = 4'b0000;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_resetb) begin
    // NOTE: the reset branch covers every flop; r_last restarts at 3 so
    // master 0 wins the first search after reset.
    if (!i_resetb) begin
      state_q   <= ST_IDLE;
      ms_en_q   <= 4'b0000;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_en_q   <= ms_en_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef SC_RR_XBAR_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // TMO_CYCLES has no function without the watchdog.
  logic unused_tmo_cycles;
  assign unused_tmo_cycles = ^TMO_CYCLES;
`endif

  assign o_ms_en   = ms_en_q;
  assign o_sl_sel  = sel_q;
  assign o_busy    = (state_q == ST_BUSY);
  assign o_timeout = timeout_q;

endmodule

// File: doc/sc_rr_crossbar_port_arbiter.md
SC_RR_CROSSBAR_PORT_ARBITER -- requirements
Module: sc_rr_crossbar_port_arbiter

Interface
REQ-001 Parameter: TMO_CYCLES, 8'd200, number of BUSY cycles without slave ack before forced release (used only with SC_RR_XBAR_TIMEOUT_EN).
REQ-002 Port: i_clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port: i_resetb  input  1  reset, asynchronous, active-low.
REQ-004 Port: i_ms_req  input  4  per-master request to this slave port, level, held until ack.
REQ-005 Port: i_sl_ack  input  1  slave transaction-complete strobe, one cycle.
REQ-006 Port: o_ms_en  output  4  one-hot grant to master n, registered.
REQ-007 Port: o_sl_sel  output  2  binary index of granted master, registered; valid while o_busy=1.
REQ-008 Port: o_busy  output  1  slave port owned (state BUSY).
REQ-009 Port: o_timeout  output  1  one-cycle pulse on forced release; constant 0 without SC_RR_XBAR_TIMEOUT_EN.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE, BUSY.
REQ-011 In IDLE with i_ms_req!=0 it SHALL grant the first requesting master scanning r_last+1, r_last+2, r_last+3, r_last (mod 4), where r_last is a 2-bit pointer to the most recently granted master.
REQ-012 Grant latency SHALL be one cycle: request sampled in IDLE at edge k -> o_ms_en/o_sl_sel/o_busy valid after edge k, state BUSY.
REQ-013 On grant, r_last SHALL be loaded with the granted index.
REQ-014 o_ms_en SHALL be one-hot or zero at all times; zero in IDLE.
REQ-015 In BUSY, i_sl_ack=1 SHALL clear o_ms_en and o_busy at the next edge and return to IDLE.
REQ-016 In BUSY, deassertion of the granted master's request bit (abort) SHALL clear o_ms_en and o_busy at the next edge and return to IDLE; other masters' request changes SHALL NOT affect BUSY.
REQ-017 Ack and abort in the same cycle SHALL be treated as a single release.
REQ-018 i_sl_ack while IDLE SHALL be ignored.
REQ-019 After any release at least one IDLE cycle SHALL elapse before the next grant (no same-edge re-grant).
REQ-020 A single persistent requester SHALL be re-granted after every release (one IDLE cycle between grants).
REQ-021 o_sl_sel SHALL hold its last value in IDLE.

Reset
REQ-022 Asserted i_resetb SHALL immediately force: state IDLE, o_ms_en=4'b0000, o_busy=0, o_timeout=0, o_sl_sel=2'd0, r_last=2'd3 (master 0 highest priority), timeout counter 0.
REQ-023 Reset mid-transaction SHALL drop the grant with no ack required; first grant after reset release follows REQ-011 with r_last=3.

Configuration
REQ-024 With macro SC_RR_XBAR_TIMEOUT_EN defined: an 8-bit counter SHALL clear on grant, increment each BUSY cycle, and on reaching TMO_CYCLES without ack or abort SHALL clear o_ms_en/o_busy, pulse o_timeout for one cycle and return to IDLE; r_last keeps the timed-out master so it gets lowest priority next; ack in the same cycle as expiry SHALL take precedence (no pulse).
REQ-025 Without SC_RR_XBAR_TIMEOUT_EN: no counter is built, BUSY persists until ack or abort, o_timeout tied 0, TMO_CYCLES unused.

Verification
REQ-026 Reset, then i_ms_req=4'b1111 held, ack 3 cycles after each grant -> grant order 0,1,2,3,0 with o_sl_sel 0,1,2,3,0 and one IDLE cycle between grants.
REQ-027 After grant to master 2, i_ms_req=4'b1011 -> next grant master 3, then 0, then 1.
REQ-028 Granted master 1 drops request (i_ms_req 4'b0010->4'b0000) while BUSY -> o_ms_en=0, o_busy=0 next edge, no ack needed; stray i_sl_ack in IDLE -> no change.
REQ-029 i_resetb pulsed low while o_ms_en=4'b0100 -> outputs zero immediately; after release with i_ms_req=4'b1100 -> master 2 granted.
REQ-030 With SC_RR_XBAR_TIMEOUT_EN, TMO_CYCLES=8'd10, master 0 granted, no ack -> o_timeout pulses once 10 BUSY cycles after grant, grant drops; with i_ms_req=4'b0011 next grant is master 1; ack on expiry cycle -> o_timeout stays 0.
REQ-031 Random i_ms_req/i_sl_ack for 10000 cycles -> o_ms_en never multi-hot, no requester starved longer than 4 grants.
